// File: rtl/register_file_pipelined_if.sv
// register_file_pipelined_if: read, write and PC port bundle of the register file
interface register_file_pipelined_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] left_register_num, right_register_num, write_register_num;
  logic [WIDTH-1:0] left_register_out, right_register_out, pc_register_out;
  logic [WIDTH-1:0] write_register_in, pc_write_in;
  logic [2:0] cond_bit_out;
  logic write_en, pc_write_en, busy;
  modport master (
    output left_register_num, right_register_num, write_register_num,
    output write_register_in, write_en, pc_write_en, pc_write_in,
    input left_register_out, right_register_out, pc_register_out, cond_bit_out, busy
  );
  modport slave (
    input left_register_num, right_register_num, write_register_num,
    input write_register_in, write_en, pc_write_en, pc_write_in,
    output left_register_out, right_register_out, pc_register_out, cond_bit_out, busy
  );
endinterface

// File: rtl/register_file_pipelined.sv
// register_file_pipelined: 2R/2W register file with bypassed registered reads, PC port, flags and post-reset clear
module register_file_pipelined #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int PC_REG = 6,
  parameter int ZERO_REG = 1
) (
  input logic clk,
  input logic rst,
  register_file_pipelined_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PC = AW'(PC_REG);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_next;
  logic run;
  logic [AW-1:0] cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] gen_val, left_val, right_val, pc_val;

  function automatic logic [WIDTH-1:0] rd(
    input logic [AW-1:0] a,
    input logic [WIDTH-1:0] stored,
    input logic [AW-1:0] wn,
    input logic we,
    input logic [WIDTH-1:0] gv,
    input logic pwe,
    input logic [WIDTH-1:0] pv
  );
    return (ZERO_REG != 0 && a == '0) ? '0 :
           (we && wn == a) ? gv :
           (pwe && a == PC) ? pv : stored;
  endfunction

  // state register
  always_ff @(posedge clk) state <= rst ? CLEAR : state_next;

  // leave CLEAR once the last entry has been zeroed
  always_comb state_next = (state == CLEAR && &cnt) ? RUN : state;

  // FSM outputs
  always_comb begin
    run = state == RUN;
    bus.busy = state == CLEAR;
  end

  // clear engine address counter
  always_ff @(posedge clk) cnt <= (rst || state != CLEAR) ? '0 : cnt + 1'b1;

  // stored value of the general port and bypassed read values
  always_comb begin
    gen_val = (ZERO_REG != 0 && bus.write_register_num == '0) ? '0 : bus.write_register_in;
    left_val = rd(bus.left_register_num, mem[bus.left_register_num], bus.write_register_num,
                  bus.write_en, gen_val, bus.pc_write_en, bus.pc_write_in);
    right_val = rd(bus.right_register_num, mem[bus.right_register_num], bus.write_register_num,
                   bus.write_en, gen_val, bus.pc_write_en, bus.pc_write_in);
    pc_val = rd(PC, mem[PC], bus.write_register_num,
                bus.write_en, gen_val, bus.pc_write_en, bus.pc_write_in);
  end

  // array update: clear sweep, else PC then general write so the general port wins on PC_REG
  always_ff @(posedge clk)
    if (!rst && !run) mem[cnt] <= '0;
    else if (!rst) begin
      if (bus.pc_write_en) mem[PC] <= bus.pc_write_in;
      if (bus.write_en) mem[bus.write_register_num] <= gen_val;
    end

  // registered read ports and condition flags
  always_ff @(posedge clk)
    if (rst || !run) begin
      bus.left_register_out <= '0;
      bus.right_register_out <= '0;
      bus.pc_register_out <= '0;
      bus.cond_bit_out <= 3'b000;
    end else begin
      bus.left_register_out <= left_val;
      bus.right_register_out <= right_val;
      bus.pc_register_out <= pc_val;
      if (bus.write_en)
        bus.cond_bit_out <= {gen_val == '0, gen_val != '0 && !gen_val[WIDTH-1], gen_val[WIDTH-1]};
    end
endmodule
